caravel_wb_gpio: RTL and testbench
==================================

CARAVEL_WB_GPIO -- requirements
Module: caravel_wb_gpio

Interface
REQ-001 Parameter BASE_ADDR, default 32'h3000_0000, SHALL be the byte address of register window (32 bytes, aligned).
REQ-002 Parameter SYNC_STAGES, default 2, SHALL be the input synchronizer depth (legal 2..3).
REQ-003 One clock, reset synchronous active-high: caravel_wb_clk_i  in  1  clock, all state on rising edge.
REQ-004 caravel_wb_rst_i  in  1  synchronous active-high reset.
REQ-005 caravel_wbs_stb_i / caravel_wbs_cyc_i / caravel_wbs_we_i  in  1 each  Wishbone classic strobe, cycle, write enable.
REQ-006 caravel_wbs_sel_i  in  4  byte lane selects; caravel_wbs_dat_i  in  32  write data; caravel_wbs_adr_i  in  32  byte address.
REQ-007 caravel_wbs_ack_o  out  1  acknowledge; caravel_wbs_dat_o  out  32  read data.
REQ-008 gpio_i  in  38  pad inputs (asynchronous); gpio_o  out  38  pad output values; gpio_oeb_no  out  38  per-pin output enable, low = drive.
REQ-009 irq_o  out  1  level interrupt to caravel_interrupt_o[0].

Function
REQ-010 Hit SHALL be cyc&stb&(adr[31:5]==BASE_ADDR[31:5]); non-hits SHALL produce no ack and no state change.
REQ-011 Register map by adr[4:2]: 0 OUT_LO[31:0], 1 OUT_HI[5:0], 2 OEB_LO[31:0], 3 OEB_HI[5:0], 4 IN_LO (RO), 5 IN_HI (RO, [5:0]), 6 IRQ_EN[31:0], 7 IRQ_PEND[31:0] (W1C).
REQ-012 Ack SHALL assert exactly one cycle after a hit is sampled with ack low, for one cycle; ack SHALL not assert on the cycle following an ack (no back-to-back acks; held strobe gets ack every other cycle).
REQ-013 Writes SHALL commit on the edge that raises ack, per byte lane per sel_i; unimplemented bits read 0, writes to RO registers ignored.
REQ-014 Read data SHALL be registered and valid while ack high; caravel_wbs_dat_o SHALL be 0 when ack low.
REQ-015 gpio_o = {OUT_HI,OUT_LO}, gpio_oeb_no = {OEB_HI,OEB_LO}, driven directly from registers (visible cycle after write commit).
REQ-016 gpio_i SHALL pass SYNC_STAGES flops; IN registers SHALL read final stage; pin change to IN visibility = SYNC_STAGES cycles.
REQ-017 Rising edge on synchronized gpio[31:0] (final stage 1, previous value 0) SHALL set IRQ_PEND bit on the following edge.
REQ-018 W1C write of 1 clears PEND bit; edge-set and W1C-clear same bit same cycle: set SHALL win.
REQ-019 irq_o SHALL be registered |(IRQ_PEND & IRQ_EN), one cycle after PEND/EN change.
REQ-020 PEND bits SHALL set regardless of IRQ_EN; enabling a pending bit SHALL raise irq_o.

Reset
REQ-021 On reset: OUT=0, OEB all 1 (all pins input), IRQ_EN=0, IRQ_PEND=0, sync/edge flops 0, ack 0, dat_o 0, irq_o 0.
REQ-022 Reset during an in-flight access SHALL abandon it: no ack, no write commit; first post-reset hit is handled normally.
REQ-023 Sync stages resetting to 0 SHALL NOT create a spurious edge on the first post-reset cycle for pins held low; pins held high produce one edge after SYNC_STAGES cycles (documented behaviour).

Configuration
REQ-024 Macro GPIO_FALL_EDGE_IRQ_EN defined: register offset 5 upper bits [31:6] unchanged; add IRQ_POL as new offset via adr[4:2]=5 write-only alias is forbidden -- instead IRQ_EN bit semantics extend: a second register IRQ_FALL[31:0] SHALL occupy BASE+0x20 (window 64 bytes, adr[31:6] match), and a falling edge on pin n with IRQ_FALL[n]=1 SHALL also set PEND[n].
REQ-025 Macro undefined: window is 32 bytes, only rising edges set PEND, BASE+0x20 is a non-hit (no ack).

Verification
REQ-026 Reset, read all 8 offsets -> OUT 0, OEB_LO 32'hFFFF_FFFF, OEB_HI 32'h3F, EN 0, PEND 0; each ack exactly one cycle.
REQ-027 Write OUT_LO 32'hA5A5_A5A5 sel=4'b0011, then read -> 32'h0000_A5A5; gpio_o[15:0]=16'hA5A5 cycle after ack.
REQ-028 Raise gpio_i[3] 0->1 with EN[3]=1 -> PEND[3]=1 and irq_o=1 within SYNC_STAGES+2 cycles; W1C 32'h8 -> irq_o 0 next cycle.
REQ-029 W1C PEND[3] on the same cycle a new edge on gpio_i[3] sets it -> PEND[3] remains 1, irq_o stays 1.
REQ-030 Access adr=BASE_ADDR+32'h100 held 20 cycles -> ack never asserts, no register changes; assert reset mid-hit -> no ack, OUT unchanged.
REQ-031 With GPIO_FALL_EDGE_IRQ_EN: IRQ_FALL[7]=1, drop gpio_i[7] 1->0 -> PEND[7]=1; without macro same stimulus -> PEND[7]=0, BASE+0x20 unacked.

Source files
------------

// File: rtl/caravel_wb_gpio.sv
// Wishbone-mapped 38-pin GPIO with synchronized inputs and edge-triggered interrupts.
// Define GPIO_FALL_EDGE_IRQ_EN to add IRQ_FALL at BASE+0x20 and widen the window to 64 bytes.
module caravel_wb_gpio #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        caravel_wb_clk_i,
    input  logic        caravel_wb_rst_i,
    input  logic        caravel_wbs_stb_i,
    input  logic        caravel_wbs_cyc_i,
    input  logic        caravel_wbs_we_i,
    input  logic [3:0]  caravel_wbs_sel_i,
    input  logic [31:0] caravel_wbs_dat_i,
    input  logic [31:0] caravel_wbs_adr_i,
    output logic        caravel_wbs_ack_o,
    output logic [31:0] caravel_wbs_dat_o,
    input  logic [37:0] gpio_i,
    output logic [37:0] gpio_o,
    output logic [37:0] gpio_oeb_no,
    output logic        irq_o
);
`ifdef GPIO_FALL_EDGE_IRQ_EN
    localparam int WIN_BITS = 6;
`else
    localparam int WIN_BITS = 5;
`endif

    logic        clk;
    logic        srst;
    logic        hit;
    logic        access;
    logic        wr_en;
    logic [3:0]  offset;
    logic [31:0] wmask;
    logic [31:0] wdata_m;
    logic [31:0] w1c;
    logic [31:0] edge_set;
    logic [31:0] rdata;
    logic        unused_adr;

    logic [SYNC_STAGES-1:0][37:0] sync_reg;
    logic [37:0] pin_sync;
    logic [31:0] prev_reg;

    logic        ack_reg;
    logic [31:0] dat_reg;
    logic        irq_reg;
    logic [31:0] out_lo_reg, out_lo_next;
    logic [5:0]  out_hi_reg, out_hi_next;
    logic [31:0] oeb_lo_reg, oeb_lo_next;
    logic [5:0]  oeb_hi_reg, oeb_hi_next;
    logic [31:0] irq_en_reg, irq_en_next;
    logic [31:0] irq_pend_reg, irq_pend_next;
`ifdef GPIO_FALL_EDGE_IRQ_EN
    logic [31:0] irq_fall_reg, irq_fall_next;
`endif

    assign clk        = caravel_wb_clk_i;
    assign srst       = caravel_wb_rst_i;
    assign unused_adr = &{1'b0, caravel_wbs_adr_i[1:0]};

    assign hit    = caravel_wbs_cyc_i & caravel_wbs_stb_i &
                    (caravel_wbs_adr_i[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]);
    assign offset = 4'(caravel_wbs_adr_i[WIN_BITS-1:2]);
    // A hit seen while ack is high is the tail of the previous cycle, not a new access.
    assign access = hit & ~ack_reg;
    assign wr_en  = access & caravel_wbs_we_i;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign wmask[8*gi +: 8] = {8{caravel_wbs_sel_i[gi]}};
        end
    endgenerate
    assign wdata_m = caravel_wbs_dat_i & wmask;

    assign pin_sync = sync_reg[SYNC_STAGES-1];
`ifdef GPIO_FALL_EDGE_IRQ_EN
    assign edge_set = (pin_sync[31:0] & ~prev_reg) | (~pin_sync[31:0] & prev_reg & irq_fall_reg);
`else
    assign edge_set = pin_sync[31:0] & ~prev_reg;
`endif

    always_comb begin
        out_lo_next = out_lo_reg;
        out_hi_next = out_hi_reg;
        oeb_lo_next = oeb_lo_reg;
        oeb_hi_next = oeb_hi_reg;
        irq_en_next = irq_en_reg;
`ifdef GPIO_FALL_EDGE_IRQ_EN
        irq_fall_next = irq_fall_reg;
`endif
        w1c = '0;
        if (wr_en) begin
            case (offset)
                4'd0: out_lo_next = (out_lo_reg & ~wmask) | wdata_m;
                4'd1: out_hi_next = (out_hi_reg & ~wmask[5:0]) | wdata_m[5:0];
                4'd2: oeb_lo_next = (oeb_lo_reg & ~wmask) | wdata_m;
                4'd3: oeb_hi_next = (oeb_hi_reg & ~wmask[5:0]) | wdata_m[5:0];
                4'd6: irq_en_next = (irq_en_reg & ~wmask) | wdata_m;
                4'd7: w1c = wdata_m;
`ifdef GPIO_FALL_EDGE_IRQ_EN
                4'd8: irq_fall_next = (irq_fall_reg & ~wmask) | wdata_m;
`endif
                default: ;
            endcase
        end
        // A fresh edge outranks a simultaneous clear so no event is lost.
        irq_pend_next = (irq_pend_reg & ~w1c) | edge_set;
    end

    always_comb begin
        rdata = '0;
        case (offset)
            4'd0: rdata = out_lo_reg;
            4'd1: rdata = {26'b0, out_hi_reg};
            4'd2: rdata = oeb_lo_reg;
            4'd3: rdata = {26'b0, oeb_hi_reg};
            4'd4: rdata = pin_sync[31:0];
            4'd5: rdata = {26'b0, pin_sync[37:32]};
            4'd6: rdata = irq_en_reg;
            4'd7: rdata = irq_pend_reg;
`ifdef GPIO_FALL_EDGE_IRQ_EN
            4'd8: rdata = irq_fall_reg;
`endif
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            sync_reg     <= '0;
            prev_reg     <= '0;
            ack_reg      <= 1'b0;
            dat_reg      <= '0;
            irq_reg      <= 1'b0;
            out_lo_reg   <= '0;
            out_hi_reg   <= '0;
            oeb_lo_reg   <= '1;
            oeb_hi_reg   <= '1;
            irq_en_reg   <= '0;
            irq_pend_reg <= '0;
`ifdef GPIO_FALL_EDGE_IRQ_EN
            irq_fall_reg <= '0;
`endif
        end else begin
            sync_reg     <= {sync_reg[SYNC_STAGES-2:0], gpio_i};
            prev_reg     <= pin_sync[31:0];
            ack_reg      <= access;
            dat_reg      <= access ? rdata : 32'h0;
            irq_reg      <= |(irq_pend_reg & irq_en_reg);
            out_lo_reg   <= out_lo_next;
            out_hi_reg   <= out_hi_next;
            oeb_lo_reg   <= oeb_lo_next;
            oeb_hi_reg   <= oeb_hi_next;
            irq_en_reg   <= irq_en_next;
            irq_pend_reg <= irq_pend_next;
`ifdef GPIO_FALL_EDGE_IRQ_EN
            irq_fall_reg <= irq_fall_next;
`endif
        end
    end

    assign caravel_wbs_ack_o = ack_reg;
    assign caravel_wbs_dat_o = dat_reg;
    assign gpio_o            = {out_hi_reg, out_lo_reg};
    assign gpio_oeb_no       = {oeb_hi_reg, oeb_lo_reg};
    assign irq_o             = irq_reg;
endmodule

// File: tb/tb_caravel_wb_gpio.sv
// Scoreboard bench for caravel_wb_gpio: randomized bus/pin stimulus against a register-level model.
module tb_caravel_wb_gpio;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int SYNC = 2;
`ifdef GPIO_FALL_EDGE_IRQ_EN
    localparam int WIN = 64;
`else
    localparam int WIN = 32;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] wdat = '0, adr = '0;
    logic [37:0] gpio_drv = '0;
    logic        ack;
    logic [31:0] rdat;
    logic [37:0] gpio_out, gpio_oeb;
    logic        irq;

    caravel_wb_gpio #(.BASE_ADDR(BASE), .SYNC_STAGES(SYNC)) dut (
        .caravel_wb_clk_i (clk),
        .caravel_wb_rst_i (rst),
        .caravel_wbs_stb_i(stb),
        .caravel_wbs_cyc_i(cyc),
        .caravel_wbs_we_i (we),
        .caravel_wbs_sel_i(sel),
        .caravel_wbs_dat_i(wdat),
        .caravel_wbs_adr_i(adr),
        .caravel_wbs_ack_o(ack),
        .caravel_wbs_dat_o(rdat),
        .gpio_i           (gpio_drv),
        .gpio_o           (gpio_out),
        .gpio_oeb_no      (gpio_oeb),
        .irq_o            (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_read;
        logic [31:0] data;
        int          off;
    } exp_t;
    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: architectural register contents and the settled pin levels.
    logic [37:0] out_m, oeb_m, pins_m;
    logic [31:0] en_m, pend_m, fall_m;

    function automatic logic [31:0] lane_mask(input logic [3:0] s);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) if (s[i]) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] m;
        m = lane_mask(s);
        return (old & ~m) | (d & m);
    endfunction

    function automatic logic [31:0] model_read(input int off);
        case (off)
            0: return out_m[31:0];
            1: return {26'b0, out_m[37:32]};
            2: return oeb_m[31:0];
            3: return {26'b0, oeb_m[37:32]};
            4: return pins_m[31:0];
            5: return {26'b0, pins_m[37:32]};
            6: return en_m;
            7: return pend_m;
            8: return fall_m;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_write(input int off, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] t;
        case (off)
            0: out_m[31:0] = merge(out_m[31:0], d, s);
            1: begin t = merge({26'b0, out_m[37:32]}, d, s); out_m[37:32] = t[5:0]; end
            2: oeb_m[31:0] = merge(oeb_m[31:0], d, s);
            3: begin t = merge({26'b0, oeb_m[37:32]}, d, s); oeb_m[37:32] = t[5:0]; end
            6: en_m = merge(en_m, d, s);
            7: pend_m = pend_m & ~(d & lane_mask(s));
            8: if (WIN == 64) fall_m = merge(fall_m, d, s);
            default: ;
        endcase
    endtask

    task automatic model_pins(input logic [37:0] nv);
        logic [31:0] rise, fall;
        rise   = nv[31:0] & ~pins_m[31:0];
        fall   = ~nv[31:0] & pins_m[31:0] & fall_m;
        pend_m = pend_m | rise | fall;
        pins_m = nv;
    endtask

    task automatic model_reset();
        out_m = '0; oeb_m = '1; en_m = '0; pend_m = '0; fall_m = '0; pins_m = '0;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every acked beat pops the scoreboard; idle cycles must show zero read data.
    bit prev_ack = 1'b0;
    always @(negedge clk) begin
        if (ack === 1'b1) begin
            if (prev_ack) begin
                n_checks++; n_fail++;
                $display("FAIL ack_back_to_back: got two consecutive acks, expected one");
            end
            if (sb_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_ack: got ack with no access outstanding, expected none");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (e.is_read) begin
                    n_checks++;
                    if (rdat !== e.data) begin
                        n_fail++;
                        $display("FAIL read_off%0d: got %h, expected %h", e.off, rdat, e.data);
                    end
                end
            end
        end else begin
            n_checks++;
            if (rdat !== 32'h0) begin
                n_fail++;
                $display("FAIL dat_idle: got %h, expected 00000000", rdat);
            end
        end
        prev_ack = (ack === 1'b1);
    end

    // Callers are always #1 after a rising edge when they issue a transaction.
    task automatic bus(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bit is_hit, got;
        int off;
        exp_t e;
        is_hit = (32'(a - BASE) < 32'(WIN));
        off    = int'(32'(a - BASE) >> 2);
        got    = 1'b0;
        if (is_hit) begin
            e.is_read = !w;
            e.data    = w ? 32'h0 : model_read(off);
            e.off     = off;
            sb_q.push_back(e);
            if (w) model_write(off, d, s);
        end
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        if (is_hit) begin
            for (int i = 0; i < 8 && !got; i++) begin
                @(posedge clk); #1;
                got = (ack === 1'b1);
            end
            check("ack_seen", 64'(got), 64'd1);
        end else begin
            for (int i = 0; i < 20; i++) begin
                @(posedge clk); #1;
                if (ack === 1'b1) got = 1'b1;
            end
            check("nonhit_noack", 64'(got), 64'd0);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        $display("%s adr=%h dat=%h sel=%b hit=%0d exp=%h", w ? "WR" : "RD", a, d, s, is_hit,
                 (is_hit && !w) ? e.data : 32'h0);
    endtask

    task automatic settle();
        repeat (SYNC + 3) @(posedge clk);
        #1;
    endtask

    task automatic set_pins(input logic [37:0] nv);
        gpio_drv = nv;
        settle();
        model_pins(nv);
        check("irq_level", 64'(irq), 64'(|(pend_m & en_m)));
    endtask

    task automatic check_outs();
        check("gpio_o", 64'(gpio_out), 64'(out_m));
        check("gpio_oeb_no", 64'(gpio_oeb), 64'(oeb_m));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] r64;
        logic [31:0] a;
        int r, cnt;
        bit got;

        // Reset with all pins low: no spurious edges.
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("ack_in_reset", 64'(ack), 64'd0);
        rst = 1'b0;
        settle();
        model_pins(gpio_drv);
        check_outs();
        check("irq_reset", 64'(irq), 64'd0);
        check("ack_reset", 64'(ack), 64'd0);
        for (int o = 0; o < 8; o++) bus(1'b0, BASE + 32'(4 * o), 32'h0, 4'hF);

        // Partial-lane write.
        bus(1'b1, BASE, 32'hA5A5_A5A5, 4'b0011);
        check("gpio_o_lo16", 64'(gpio_out[15:0]), 64'h0000_0000_0000_A5A5);
        bus(1'b0, BASE, 32'h0, 4'hF);

        // Held strobe: ack every other cycle.
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            e.is_read = 1'b1; e.data = model_read(2); e.off = 2;
            sb_q.push_back(e);
        end
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h8; sel = 4'hF;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ack === 1'b1) cnt++;
        end
        cyc = 1'b0; stb = 1'b0;
        check("held_stb_acks", 64'(cnt), 64'd3);

        // Randomized register traffic and pin activity.
        for (int it = 0; it < 70; it++) begin
            r = $urandom_range(0, 9);
            if (r < 4) begin
                a = BASE + 32'(4 * $urandom_range(0, WIN / 4 - 1));
                bus(1'b1, a, $urandom, 4'($urandom_range(1, 15)));
                check_outs();
            end else if (r < 8) begin
                bus(1'b0, BASE + 32'(4 * $urandom_range(0, WIN / 4 - 1)), 32'h0, 4'hF);
            end else begin
                r64 = {$urandom, $urandom};
                set_pins(r64[37:0]);
            end
        end

        // Rising edge on pin 3 raises irq, W1C drops it.
        bus(1'b1, BASE + 32'h18, 32'h8, 4'hF);
        set_pins(gpio_drv & ~38'h8);
        bus(1'b1, BASE + 32'h1C, 32'hFFFF_FFFF, 4'hF);
        @(posedge clk); #1;
        check("irq_cleared_all", 64'(irq), 64'd0);
        gpio_drv[3] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < SYNC + 2; i++) begin
            @(posedge clk); #1;
            if (irq === 1'b1) got = 1'b1;
        end
        check("irq_rise_latency", 64'(got), 64'd1);
        model_pins(gpio_drv);
        bus(1'b0, BASE + 32'h1C, 32'h0, 4'hF);
        bus(1'b1, BASE + 32'h1C, 32'h8, 4'hF);
        @(posedge clk); #1;
        check("irq_after_w1c", 64'(irq), 64'd0);

        // Edge set and W1C on the same edge: set wins.
        gpio_drv[3] = 1'b0; settle(); model_pins(gpio_drv);
        set_pins(gpio_drv | 38'h8);
        check("irq_pre_race", 64'(irq), 64'd1);
        gpio_drv[3] = 1'b0; settle(); model_pins(gpio_drv);
        gpio_drv[3] = 1'b1;
        repeat (SYNC) @(posedge clk);
        #1;
        bus(1'b1, BASE + 32'h1C, 32'h8, 4'hF);
        model_pins(gpio_drv);
        check("irq_race_now", 64'(irq), 64'd1);
        @(posedge clk); #1;
        check("irq_race_next", 64'(irq), 64'd1);
        bus(1'b0, BASE + 32'h1C, 32'h0, 4'hF);

        // Out-of-window access is ignored.
        bus(1'b1, BASE + 32'h100, $urandom, 4'hF);
        bus(1'b0, BASE, 32'h0, 4'hF);

        // Fall-edge register at BASE+0x20.
        bus(1'b1, BASE + 32'h20, 32'h80, 4'hF);
        set_pins(gpio_drv | 38'h80);
        bus(1'b1, BASE + 32'h1C, 32'hFFFF_FFFF, 4'hF);
        set_pins(gpio_drv & ~38'h80);
        bus(1'b0, BASE + 32'h1C, 32'h0, 4'hF);

        // Reset in the middle of a write, with random pins held across reset.
        r64 = {$urandom, $urandom};
        gpio_drv = r64[37:0];
        @(posedge clk); #1;
        rst = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE; wdat = 32'hFFFF_FFFF; sel = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("ack_mid_reset", 64'(ack), 64'd0);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0; rst = 1'b0;
        model_reset();
        settle();
        model_pins(gpio_drv);
        check_outs();
        bus(1'b0, BASE, 32'h0, 4'hF);
        bus(1'b0, BASE + 32'h1C, 32'h0, 4'hF);
        bus(1'b1, BASE, 32'h1234_5678, 4'hF);
        check_outs();
        bus(1'b0, BASE, 32'h0, 4'hF);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
